// File: rtl/ahb_dma_master_if.sv
// AHB-Lite bus bundle between the DMA initiator and the system bus.
// A phase completes on a rising edge with HREADY=1; the master holds address/control while HREADY=0.
interface ahb_dma_master_if;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_dma_master.sv
// AHB-Lite DMA initiator: copies LEN words from SRC_ADDR to DST_ADDR, one NONSEQ SINGLE per beat.
// Optional sticky completion interrupt (IRQ/IRQ_CLR) when AHB_DMA_IRQ_EN is defined.
module ahb_dma_master #(
   parameter int          LEN_W     = 16,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [31:0]       SRC_ADDR,
   input  logic [31:0]       DST_ADDR,
   input  logic [LEN_W-1:0]  LEN,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
`ifdef AHB_DMA_IRQ_EN
   output logic              IRQ,
   input  logic              IRQ_CLR,
`endif
   output logic [2:0]        DBG_STATE,
   ahb_dma_master_if.master  ahb
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_D = 3'd2,
      S_WR_A = 3'd3,
      S_WR_D = 3'd4,
      S_FIN  = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       src_q, src_d;
   logic [31:0]       dst_q, dst_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [31:0]       buf_q, buf_d;
   logic              err_q, err_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      buf_d   = buf_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (LEN != '0) begin
                  src_d   = {SRC_ADDR[31:2], 2'b00};
                  dst_d   = {DST_ADDR[31:2], 2'b00};
                  rem_d   = LEN;
                  state_d = S_RD_A;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_RD_A: if (ahb.HREADY) state_d = S_RD_D;
         S_RD_D: begin
            if (ahb.HREADY) begin
               if (ahb.HRESP) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  buf_d   = ahb.HRDATA;
                  state_d = S_WR_A;
               end
            end
         end
         S_WR_A: if (ahb.HREADY) state_d = S_WR_D;
         S_WR_D: begin
            if (ahb.HREADY) begin
               if (ahb.HRESP) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // Addresses wrap modulo 2^32; the counter saturates at zero.
                  src_d   = src_q + 32'd4;
                  dst_d   = dst_q + 32'd4;
                  rem_d   = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
                  state_d = (rem_q <= LEN_W'(1)) ? S_FIN : S_RD_A;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign ahb.HADDR     = (state_q == S_RD_A) ? src_q :
                          (state_q == S_WR_A) ? dst_q : 32'h0;
   assign ahb.HTRANS    = ((state_q == S_RD_A) || (state_q == S_WR_A)) ? 2'b10 : 2'b00;
   assign ahb.HWRITE    = (state_q == S_WR_A);
   assign ahb.HSIZE     = 3'b010;
   assign ahb.HBURST    = 3'b000;
   assign ahb.HPROT     = HPROT_VAL;
   assign ahb.HMASTLOCK = 1'b0;
   assign ahb.HWDATA    = buf_q;

   assign BUSY      = (state_q != S_IDLE) && (state_q != S_FIN);
   assign DONE      = (state_q == S_FIN);
   assign ERR       = err_q;
   assign DBG_STATE = state_q;

`ifdef AHB_DMA_IRQ_EN
   logic irq_q;

   // A new completion beats a simultaneous clear.
   always_ff @(posedge CLK) begin
      if (RESET)              irq_q <= 1'b0;
      else if (DONE || ERR)   irq_q <= 1'b1;
      else if (IRQ_CLR)       irq_q <= 1'b0;
   end

   assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_ahb_dma_master.sv
// Bench for ahb_dma_master: memory slave model with wait/error injection and an expected-transfer scoreboard.
`timescale 1ns/1ps
module tb_ahb_dma_master;
   localparam int LEN_W = 16;
   localparam int LIMIT = 2000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [31:0]       src_addr, dst_addr;
   logic [LEN_W-1:0]  len;
   logic              busy, done, err;
   logic [2:0]        dbg_state;
`ifdef AHB_DMA_IRQ_EN
   logic              irq, irq_clr;
`endif

   ahb_dma_master_if bus ();

   ahb_dma_master #(.LEN_W(LEN_W), .HPROT_VAL(4'b0011)) dut (
      .CLK       (clk),
      .RESET     (rst),
      .START     (start),
      .SRC_ADDR  (src_addr),
      .DST_ADDR  (dst_addr),
      .LEN       (len),
      .BUSY      (busy),
      .DONE      (done),
      .ERR       (err),
`ifdef AHB_DMA_IRQ_EN
      .IRQ       (irq),
      .IRQ_CLR   (irq_clr),
`endif
      .DBG_STATE (dbg_state),
      .ahb       (bus.master)
   );

   always #5 clk = ~clk;

   // scoreboard state
   logic [31:0] mem [logic [31:0]];
   logic [32:0] exp_q[$];      // {hwrite, haddr} per address phase
   logic [31:0] exp_wd_q[$];   // write data per write data phase
   int vectors = 0, miscompares = 0;
   int cyc = 0, start_cyc = 0, done_cyc = 0;
   int done_cnt = 0, err_cnt = 0, busy_cnt = 0, unexp_cnt = 0;
   int wr_beats = 0, rd_beats = 0, err_rd_idx = 0, stall_left = 0;
   bit stall_rda = 0, stall_wrd = 0, stalled_addr = 0, hready_prev = 1;
   logic dp_valid = 1'b0, dp_write = 1'b0;
   logic [31:0] dp_addr = 32'h0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // AHB memory slave: acts on the edge, then sets up the next cycle's response.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         dp_valid = 1'b0;
      end else begin
         if (dp_valid && bus.HREADY) begin
            if (dp_write) begin
               mem[dp_addr] = bus.HWDATA;
               wr_beats++;
            end
            dp_valid = 1'b0;
         end
         if (bus.HREADY && bus.HTRANS == 2'b10) begin
            dp_valid = 1'b1;
            dp_addr  = bus.HADDR;
            dp_write = bus.HWRITE;
            if (!bus.HWRITE) rd_beats++;
         end
      end
      #1;
      hready_prev = (bus.HREADY !== 1'b0);
      if (stall_left > 0) begin
         bus.HREADY = 1'b0;
         stall_left--;
      end else if (hready_prev && !rst &&
                   ((stall_rda && bus.HTRANS == 2'b10 && !bus.HWRITE) ||
                    (stall_wrd && dp_valid && dp_write))) begin
         bus.HREADY = 1'b0;
         stall_left = 2;
      end else begin
         bus.HREADY = 1'b1;
      end
      bus.HRDATA = (dp_valid && !dp_write) ? mem_rd(dp_addr) : 32'h0;
      bus.HRESP  = (dp_valid && !dp_write && err_rd_idx != 0 && rd_beats == err_rd_idx);
   end

   // monitor: compares bus activity against the expected queues
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err)  err_cnt++;
         if (busy) busy_cnt++;
         if (stalled_addr) chk("htrans_hold", {62'h0, bus.HTRANS}, 64'h2);
         if (bus.HTRANS == 2'b10) begin
            if (exp_q.size() == 0)  unexp_cnt++;
            else if (bus.HREADY)    chk("addr_phase", {31'h0, bus.HWRITE, bus.HADDR}, {31'h0, exp_q.pop_front()});
            else                    chk("addr_hold", {31'h0, bus.HWRITE, bus.HADDR}, {31'h0, exp_q[0]});
         end
         if (dp_valid && dp_write) begin
            if (exp_wd_q.size() == 0) unexp_cnt++;
            else if (bus.HREADY)      chk("hwdata", bus.HWDATA, exp_wd_q.pop_front());
            else                      chk("hwdata_hold", bus.HWDATA, exp_wd_q[0]);
         end
         stalled_addr = (bus.HTRANS == 2'b10) && !bus.HREADY;
      end else begin
         stalled_addr = 1'b0;
      end
   end

   task automatic init_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) mem[base + 32'(i * 4)] = $urandom;
   endtask

   // Pushes the expected transfer sequence, then pulses START.
   task automatic launch(input logic [31:0] src, input logic [31:0] dst,
                         input logic [LEN_W-1:0] n, input int err_at);
      logic [31:0] s, d;
      done_cnt = 0; err_cnt = 0; busy_cnt = 0; unexp_cnt = 0;
      wr_beats = 0; rd_beats = 0; done_cyc = 0;
      err_rd_idx = err_at;
      s = {src[31:2], 2'b00};
      d = {dst[31:2], 2'b00};
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back({1'b0, s + 32'(i * 4)});
         if (err_at != 0 && i == err_at - 1) break;
         exp_q.push_back({1'b1, d + 32'(i * 4)});
         exp_wd_q.push_back(mem_rd(s + 32'(i * 4)));
      end
      @(negedge clk);
      start = 1'b1; src_addr = src; dst_addr = dst; len = n;
      start_cyc = cyc;
      @(posedge clk);
      #2 start = 1'b0;
   endtask

   task automatic wait_end();
      int budget = 0;
      while (done_cnt == 0 && err_cnt == 0 && budget < LIMIT) begin
         @(posedge clk);
         budget++;
      end
      chk("timeout", (budget >= LIMIT), 0);
      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size() + exp_wd_q.size(), 0);
      chk("no_extra_txn", unexp_cnt, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      int wait_budget;
      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef AHB_DMA_IRQ_EN
      irq_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   busy, 0);
      chk("rst_done",   done, 0);
      chk("rst_err",    err, 0);
      chk("rst_htrans", bus.HTRANS, 0);
      chk("rst_hwrite", bus.HWRITE, 0);
      chk("rst_haddr",  bus.HADDR, 0);
      chk("rst_hwdata", bus.HWDATA, 0);
      chk("rst_hsize",  bus.HSIZE, 3'b010);
      chk("rst_hprot",  bus.HPROT, 4'b0011);
      rst = 1'b0;

      // basic 3-word copy, zero wait states
      init_words(32'h100, 3);
      launch(32'h100, 32'h200, 3, 0);
      wait_end();
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_err_cnt",  err_cnt, 0);
      chk("t1_latency",  done_cyc - start_cyc, 13);
      chk("t1_busy_cyc", busy_cnt, 12);
      for (int i = 0; i < 3; i++) chk("t1_mem", mem_rd(32'h200 + 32'(i * 4)), mem_rd(32'h100 + 32'(i * 4)));
`ifdef AHB_DMA_IRQ_EN
      chk("irq_set", irq, 1);
      repeat (3) @(negedge clk);
      chk("irq_sticky", irq, 1);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk("irq_cleared", irq, 0);
`endif

      // zero length: FIN follows IDLE directly, no bus traffic
      launch(32'h900, 32'hA00, 0, 0);
      wait_end();
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_latency",  done_cyc - start_cyc, 1);
      chk("t2_busy_cyc", busy_cnt, 0);

      // 3-cycle wait states in every read address phase and write data phase
      init_words(32'h700, 3);
      stall_rda = 1; stall_wrd = 1;
      launch(32'h703, 32'h802, 3, 0);
      wait_end();
      stall_rda = 0; stall_wrd = 0;
      chk("t3_done_cnt", done_cnt, 1);
      for (int i = 0; i < 3; i++) chk("t3_mem", mem_rd(32'h800 + 32'(i * 4)), mem_rd(32'h700 + 32'(i * 4)));

      // error response on the 2nd read data phase
      init_words(32'h300, 4);
      launch(32'h300, 32'h400, 4, 2);
      wait_end();
      err_rd_idx = 0;
      chk("t4_err_cnt",  err_cnt, 1);
      chk("t4_done_cnt", done_cnt, 0);
      chk("t4_wr_beats", wr_beats, 1);

      // address wrap plus an ignored second START
      init_words(32'hFFFF_FFFC, 2);
      init_words(32'h2000, 5);
      launch(32'hFFFF_FFFC, 32'h1000, 2, 0);
      repeat (3) @(negedge clk);
      start = 1'b1; src_addr = 32'h2000; dst_addr = 32'h3000; len = 5;
      @(negedge clk);
      start = 1'b0;
      wait_end();
      chk("t5_done_cnt", done_cnt, 1);
      chk("t5_wr_beats", wr_beats, 2);
      chk("t5_mem0", mem_rd(32'h1000), mem_rd(32'hFFFF_FFFC));
      chk("t5_mem1", mem_rd(32'h1004), mem_rd(32'h0));

      // reset during a write address phase
      init_words(32'h500, 2);
      launch(32'h500, 32'h600, 2, 0);
      wait_budget = 0;
      while (!(bus.HTRANS == 2'b10 && bus.HWRITE) && wait_budget < 50) begin
         @(negedge clk);
         wait_budget++;
      end
      chk("t6_reach_wr_a", (wait_budget >= 50), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_htrans", bus.HTRANS, 0);
      chk("t6_busy",   busy, 0);
      chk("t6_done",   done, 0);
      chk("t6_err",    err, 0);
`ifdef AHB_DMA_IRQ_EN
      chk("t6_irq",    irq, 0);
`endif
      rst = 1'b0;
      exp_q.delete();
      exp_wd_q.delete();
      done_cnt = 0; err_cnt = 0; unexp_cnt = 0;
      repeat (6) @(negedge clk);
      chk("t6_no_done", done_cnt, 0);
      chk("t6_no_err",  err_cnt, 0);
      chk("t6_quiet",   unexp_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
